treeval_ctrl: RTL and testbench

Sequencer that owns the `treeval` evaluator: accepts node records from a host over a valid/ready stream and serializes each into `treeval`'s one-field-per-cycle sideband writes. It then programs the node count, holds and releases `treeval`'s reset, and counts completed backward passes. After the requested pass count it captures the root expectation and action into a held result. It sits between the host/DMA front end and one `treeval` instance.

---
 rtl/treeval_pkg.sv | 49 ++++
 rtl/treeval_ctrl_field_ser.sv | 69 ++++++
 rtl/treeval_ctrl.sv | 159 +++++++++++++++
 tb/tb_treeval_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/treeval_pkg.sv
// Shared types for the treeval sequencer: widths, FSM and field enums, and the node record.
package treeval_pkg;

  localparam int W_ADDR   = 10;
  localparam int W_ACTION = 3;
  localparam int W_REWARD = 11;
  localparam int W_WEIGHT = 8;
  localparam int W_DATA   = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONF,
    S_SETTLE,
    S_RUN,
    S_RESULT
  } tvc_state_t;

  typedef enum logic [1:0] {
    F_W,
    F_P,
    F_R,
    F_A
  } tvc_field_t;

  typedef struct packed {
    logic [W_ADDR-1:0]   addr;
    logic [W_ADDR-1:0]   parent;
    logic [W_ACTION-1:0] action;
    logic [W_REWARD-1:0] reward;
    logic [W_WEIGHT-1:0] weight;
    logic                last;
  } tvc_rec_t;

  // Zero-extended value of one record field as written on mem_data.
  function automatic logic [W_DATA-1:0] field_data(input tvc_rec_t r, input tvc_field_t f);
    logic [W_DATA-1:0] d;
    d = '0;
    case (f)
      F_W:     d = W_DATA'(r.weight);
      F_P:     d = W_DATA'(r.parent);
      F_R:     d = W_DATA'(r.reward);
      F_A:     d = W_DATA'(r.action);
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/treeval_ctrl_field_ser.sv
// Holds one node record and writes its fields W,P,R,A on consecutive cycles.
// Handshake: a record transfers on a cycle where rec_valid & rec_ready are both high.
module tvc_field_ser
  import treeval_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              rec_valid,
  input  tvc_rec_t          rec,
  output logic              rec_ready,
  output logic              accept,
  output logic              last_done,
  output logic              mem_weight,
  output logic              mem_par,
  output logic              mem_rew,
  output logic              mem_act,
  output logic [W_ADDR-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_data
);

  logic       held;
  tvc_field_t phase;
  tvc_field_t nxt;
  tvc_rec_t   rec_q;
  logic [3:0] strobe;

  // A new record may overlap the A write of the held one, except after the last record.
  assign rec_ready = enable & (~held | ((phase == F_A) & ~rec_q.last));
  assign accept    = rec_valid & rec_ready;
  assign last_done = held & (phase == F_A) & rec_q.last;
  assign nxt       = tvc_field_t'(phase + 2'd1);

  assign mem_weight = strobe[0];
  assign mem_par    = strobe[1];
  assign mem_rew    = strobe[2];
  assign mem_act    = strobe[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held     <= 1'b0;
      phase    <= F_W;
      rec_q    <= '0;
      strobe   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (flush) begin
      held   <= 1'b0;
      phase  <= F_W;
      strobe <= '0;
    end else if (accept) begin
      held     <= 1'b1;
      phase    <= F_W;
      rec_q    <= rec;
      strobe   <= 4'b0001;
      mem_addr <= rec.addr;
      mem_data <= field_data(rec, F_W);
    end else if (held && phase != F_A) begin
      phase    <= nxt;
      strobe   <= 4'b0001 << nxt;
      mem_data <= field_data(rec_q, nxt);
    end else begin
      held   <= 1'b0;
      strobe <= '0;
    end
  end

endmodule

// File: rtl/treeval_ctrl.sv
// Job sequencer for one treeval: loads node records, configures the node count,
// runs the requested number of backward passes and holds the root result.
module treeval_ctrl
  import treeval_pkg::*;
#(
  parameter int W_ADDR     = treeval_pkg::W_ADDR,
  parameter int W_ACTION   = treeval_pkg::W_ACTION,
  parameter int W_REWARD   = treeval_pkg::W_REWARD,
  parameter int W_WEIGHT   = treeval_pkg::W_WEIGHT,
  parameter int W_DATA     = treeval_pkg::W_DATA,
  parameter int W_PASS     = 6,
  parameter int WDOG_LIMIT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W_PASS-1:0]   cfg_passes,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [W_ADDR-1:0]   rec_addr,
  input  logic [W_ADDR-1:0]   rec_parent,
  input  logic [W_ACTION-1:0] rec_action,
  input  logic [W_REWARD-1:0] rec_reward,
  input  logic [W_WEIGHT-1:0] rec_weight,
  input  logic                rec_last,
  output logic                tv_rst,
  output logic                mem_weight,
  output logic                mem_par,
  output logic                mem_rew,
  output logic                mem_act,
  output logic [W_ADDR-1:0]   mem_addr,
  output logic [W_DATA-1:0]   mem_data,
  output logic                conf_nodes,
  output logic [W_ADDR-1:0]   conf_data,
  input  logic                exp_change,
  input  logic [W_REWARD-1:0] exp,
  input  logic [W_ACTION-1:0] act,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                busy,
  output logic                err,
  output tvc_state_t          dbg_state
);

  tvc_state_t          state;
  tvc_state_t          state_nxt;
  tvc_rec_t            rec_in;
  logic [W_ADDR-1:0]   rec_cnt;
  logic [W_PASS-1:0]   passes_lat;
  logic [W_PASS-1:0]   pass_cnt;
  logic                exp_prev;
  logic [15:0]         wdog_cnt;
  logic                accept;
  logic                last_done;
  logic                load_err;
  logic                rise;
  logic                pass_done;
  logic                timeout;

  assign rec_in = '{addr: rec_addr, parent: rec_parent, action: rec_action,
                    reward: rec_reward, weight: rec_weight, last: rec_last};

  tvc_field_ser u_ser (
    .clk        (clk),
    .rst        (rst),
    .enable     (state == S_LOAD),
    .flush      (load_err),
    .rec_valid  (rec_valid),
    .rec        (rec_in),
    .rec_ready  (rec_ready),
    .accept     (accept),
    .last_done  (last_done),
    .mem_weight (mem_weight),
    .mem_par    (mem_par),
    .mem_rew    (mem_rew),
    .mem_act    (mem_act),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  // Overflowing the address space, or a tree with a single node, aborts the load.
  assign load_err  = accept & ((rec_cnt == '1) | (rec_last & (rec_cnt == '0)));
  assign rise      = (state == S_RUN) & exp_change & ~exp_prev;
  assign pass_done = rise & ((pass_cnt + W_PASS'(1)) == passes_lat);
  assign timeout   = (state == S_RUN) & (wdog_cnt == 16'(WDOG_LIMIT - 1));
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (load_err)       state_nxt = S_IDLE;
        else if (last_done) state_nxt = S_CONF;
      end
      S_CONF:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_RUN;
      S_RUN: begin
        if (pass_done)    state_nxt = S_RESULT;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_RESULT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tv_rst     <= 1'b1;
      conf_nodes <= 1'b0;
      conf_data  <= '0;
      res_valid  <= 1'b0;
      res_exp    <= '0;
      res_act    <= '0;
      err        <= 1'b0;
      rec_cnt    <= '0;
      passes_lat <= '0;
      pass_cnt   <= '0;
      exp_prev   <= 1'b1;
      wdog_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      tv_rst     <= (state_nxt != S_RUN);
      conf_nodes <= (state_nxt == S_CONF);
      res_valid  <= (state_nxt == S_RESULT);

      if (state == S_LOAD && state_nxt == S_CONF) conf_data <= rec_cnt;
      if (pass_done) begin
        res_exp <= exp;
        res_act <= act;
      end

      if (state == S_IDLE && start) begin
        passes_lat <= (cfg_passes == '0) ? W_PASS'(1) : cfg_passes;
        rec_cnt    <= '0;
        err        <= 1'b0;
      end else if (accept && !load_err) begin
        rec_cnt <= rec_cnt + W_ADDR'(1);
      end
      if (load_err || (timeout && !pass_done)) err <= 1'b1;

      // The edge detector starts high so a level already up at RUN entry is not a pass.
      if (state == S_SETTLE) begin
        exp_prev <= 1'b1;
        pass_cnt <= '0;
        wdog_cnt <= '0;
      end else if (state == S_RUN) begin
        exp_prev <= exp_change;
        wdog_cnt <= wdog_cnt + 16'd1;
        if (rise) pass_cnt <= pass_cnt + W_PASS'(1);
      end
    end
  end

endmodule

// File: tb/tb_treeval_ctrl.sv
// Directed bench for treeval_ctrl: the bench plays host and treeval, a monitor
// scores field writes and results against queues filled when stimulus is driven.
module tb_treeval_ctrl;
  import treeval_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [5:0]          cfg_passes = '0;
  logic                rec_valid = 1'b0;
  logic                rec_ready;
  logic [9:0]          rec_addr = '0;
  logic [9:0]          rec_parent = '0;
  logic [2:0]          rec_action = '0;
  logic [10:0]         rec_reward = '0;
  logic [7:0]          rec_weight = '0;
  logic                rec_last = 1'b0;
  logic                tv_rst;
  logic                mem_weight, mem_par, mem_rew, mem_act;
  logic [9:0]          mem_addr;
  logic [10:0]         mem_data;
  logic                conf_nodes;
  logic [9:0]          conf_data;
  logic                exp_change = 1'b1;
  logic [10:0]         exp = '0;
  logic [2:0]          act = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [10:0]         res_exp;
  logic [2:0]          res_act;
  logic                busy;
  logic                err;
  tvc_state_t          dbg_state;

  always #5 clk = ~clk;

  treeval_ctrl #(.WDOG_LIMIT(100)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
    .rec_parent(rec_parent), .rec_action(rec_action), .rec_reward(rec_reward),
    .rec_weight(rec_weight), .rec_last(rec_last), .tv_rst(tv_rst),
    .mem_weight(mem_weight), .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act),
    .mem_addr(mem_addr), .mem_data(mem_data), .conf_nodes(conf_nodes),
    .conf_data(conf_data), .exp_change(exp_change), .exp(exp), .act(act),
    .res_valid(res_valid), .res_ready(res_ready), .res_exp(res_exp),
    .res_act(res_act), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int conf_seen = 0;
  logic [22:0] exp_q[$];
  logic [13:0] res_q[$];
  int t_addr[8], t_par[8], t_act[8], t_rew[8], t_w[8];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [22:0] fw(input logic [1:0] k, input int a, input int d);
    return {k, a[9:0], d[10:0]};
  endfunction

  // Monitor: every strobe must match the next queued write; results match the result queue.
  logic res_prev = 1'b0;
  always @(negedge clk) begin
    logic [3:0]  s;
    logic [1:0]  k;
    logic [22:0] want;
    s = {mem_act, mem_rew, mem_par, mem_weight};
    if (s != 4'b0) begin
      k = s[3] ? 2'd3 : s[2] ? 2'd2 : s[1] ? 2'd1 : 2'd0;
      chk("strobe_onehot", 32'($onehot(s)), 32'd1);
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("field_write", 32'({k, mem_addr, mem_data}), 32'(want));
      end
    end
    if (conf_nodes) conf_seen++;
    if (res_valid && !res_prev) begin
      chk("res_expected", 32'(res_q.size() != 0), 32'd1);
      if (res_q.size() != 0) chk("result", 32'({res_act, res_exp}), 32'(res_q.pop_front()));
    end
    res_prev = res_valid;
  end

  task automatic set_tree3();
    t_addr[0] = 0; t_par[0] = 0; t_act[0] = 0; t_rew[0] = 0;   t_w[0] = 0;
    t_addr[1] = 1; t_par[1] = 0; t_act[1] = 0; t_rew[1] = 100; t_w[1] = 64;
    t_addr[2] = 2; t_par[2] = 0; t_act[2] = 0; t_rew[2] = -50; t_w[2] = 64;
  endtask

  function automatic int root_exp(input int n);
    int num, den;
    num = 0; den = 0;
    for (int i = 0; i < n; i++)
      if (t_par[i] == 0 && t_addr[i] != 0) begin
        num += t_w[i] * t_rew[i];
        den += t_w[i];
      end
    return (den == 0) ? 0 : num / den;
  endfunction

  // All tasks below are entered and left at a falling clock edge.
  task automatic start_job(input int p);
    cfg_passes = 6'(p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_load", 32'(dbg_state), 32'(S_LOAD));
    chk("start_err_clear", 32'(err), 32'd0);
  endtask

  task automatic send_tree(input int n, input bit expect_err);
    int cnt, acc, prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      rec_valid  = 1'b1;
      rec_addr   = 10'(t_addr[i]);
      rec_parent = 10'(t_par[i]);
      rec_action = 3'(t_act[i]);
      rec_reward = 11'(t_rew[i]);
      rec_weight = 8'(t_w[i]);
      rec_last   = (i == n - 1);
      cnt = 0;
      while (!rec_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      chk("rec_ready_wait", 32'(rec_ready), 32'd1);
      if (!expect_err) begin
        exp_q.push_back(fw(2'd0, t_addr[i], t_w[i]));
        exp_q.push_back(fw(2'd1, t_addr[i], t_par[i]));
        exp_q.push_back(fw(2'd2, t_addr[i], t_rew[i]));
        exp_q.push_back(fw(2'd3, t_addr[i], t_act[i]));
      end
      acc = cyc;
      if (i > 0) chk("ready_cadence", 32'(acc - prev), 32'd4);
      prev = acc;
      @(negedge clk);
    end
    rec_valid = 1'b0;
    rec_last  = 1'b0;
  endtask

  task automatic finish_load(input int n);
    repeat (4) @(negedge clk);
    chk("conf_nodes", 32'(conf_nodes), 32'd1);
    chk("conf_data", 32'(conf_data), 32'(n));
    @(negedge clk);
    chk("settle_state", 32'(dbg_state), 32'(S_SETTLE));
    chk("settle_tv_rst", 32'(tv_rst), 32'd1);
    @(negedge clk);
    chk("run_state", 32'(dbg_state), 32'(S_RUN));
    chk("run_tv_rst", 32'(tv_rst), 32'd0);
  endtask

  task automatic pulse(input logic [10:0] e, input logic [2:0] a, input bit capture);
    exp_change = 1'b0;
    @(negedge clk);
    exp = e;
    act = a;
    exp_change = 1'b1;
    if (capture) res_q.push_back({a, e});
    @(negedge clk);
    chk("res_valid_timing", 32'(res_valid), 32'(capture));
    chk("pass_state", 32'(dbg_state), capture ? 32'(S_RESULT) : 32'(S_RUN));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("consume_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("consume_res_valid", 32'(res_valid), 32'd0);
  endtask

  task automatic job3();
    set_tree3();
    start_job(1);
    send_tree(3, 1'b0);
    finish_load(3);
    repeat (3) @(negedge clk);
    pulse(11'(root_exp(3)), 3'd0, 1'b1);
    chk("res_exp_3node", 32'(res_exp), 32'd25);
    chk("res_act_3node", 32'(res_act), 32'd0);
    consume();
  endtask

  initial begin
    int n_run, conf_before;
    repeat (3) @(negedge clk);
    chk("rst_tv_rst", 32'(tv_rst), 32'd1);
    chk("rst_strobes", 32'({mem_weight, mem_par, mem_rew, mem_act, conf_nodes}), 32'd0);
    chk("rst_flags", 32'({rec_ready, res_valid, busy, err}), 32'd0);
    chk("rst_data", 32'({mem_addr, mem_data, conf_data}), 32'd0);
    chk("rst_res", 32'({res_exp, res_act}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // 3-node tree, one pass, back-to-back records
    job3();

    // 5-node two-level tree, two passes; result held until consumed
    t_addr[0] = 0; t_par[0] = 0; t_act[0] = 0; t_rew[0] = 0;  t_w[0] = 0;
    t_addr[1] = 1; t_par[1] = 0; t_act[1] = 1; t_rew[1] = 10; t_w[1] = 32;
    t_addr[2] = 2; t_par[2] = 0; t_act[2] = 2; t_rew[2] = 30; t_w[2] = 96;
    t_addr[3] = 3; t_par[3] = 1; t_act[3] = 3; t_rew[3] = -8; t_w[3] = 200;
    t_addr[4] = 4; t_par[4] = 1; t_act[4] = 5; t_rew[4] = 12; t_w[4] = 55;
    start_job(2);
    send_tree(5, 1'b0);
    finish_load(5);
    repeat (2) @(negedge clk);
    pulse(11'd7, 3'd1, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pulse(11'h7FD, 3'd2, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("res_hold_valid", 32'(res_valid), 32'd1);
      chk("res_hold_data", 32'({res_act, res_exp}), 32'({3'd2, 11'h7FD}));
    end
    start = 1'b1;
    cfg_passes = 6'd3;
    consume();
    start = 1'b0;
    @(negedge clk);
    chk("start_ignored", 32'(dbg_state), 32'(S_IDLE));

    // single-record tree is rejected with no writes
    conf_before = conf_seen;
    set_tree3();
    start_job(1);
    send_tree(1, 1'b1);
    chk("last_first_err", 32'(err), 32'd1);
    chk("last_first_idle", 32'(dbg_state), 32'(S_IDLE));
    repeat (6) @(negedge clk);
    chk("last_first_no_conf", 32'(conf_seen), 32'(conf_before));

    // watchdog with exp_change stuck low
    exp_change = 1'b0;
    start_job(1);
    send_tree(3, 1'b0);
    finish_load(3);
    n_run = 1;
    while (n_run < 200) begin
      @(negedge clk);
      if (dbg_state != S_RUN) break;
      n_run++;
    end
    chk("wdog_run_cycles", 32'(n_run), 32'd100);
    chk("wdog_err", 32'(err), 32'd1);
    chk("wdog_idle", 32'(dbg_state), 32'(S_IDLE));
    exp_change = 1'b1;

    // reset asserted while the held record is on its R write
    start_job(1);
    rec_valid = 1'b1; rec_addr = 10'd1; rec_parent = 10'd0;
    rec_action = 3'd0; rec_reward = 11'd100; rec_weight = 8'd64; rec_last = 1'b0;
    exp_q.push_back(fw(2'd0, 1, 64));
    exp_q.push_back(fw(2'd1, 1, 0));
    exp_q.push_back(fw(2'd2, 1, 100));
    exp_q.push_back(fw(2'd3, 1, 0));
    @(negedge clk);
    rec_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_phase_r", 32'(mem_rew), 32'd1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_strobes", 32'({mem_weight, mem_par, mem_rew, mem_act, conf_nodes}), 32'd0);
    chk("abort_tv_rst", 32'(tv_rst), 32'd1);
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_busy", 32'({busy, rec_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    job3();

    repeat (3) @(negedge clk);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("results_drained", 32'(res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no completion expected finish");
    $fatal(1);
  end

endmodule
